// File: rtl/m16_pkg.sv
// Shared definitions for the M16 imitator blocks.
//   - m16_state_e  : sequencer state encoding (IDLE, RUN, WAIT, STOP)
//   - PHRASE_WORDS : words per phrase
//   - FRAME_PHRASES: phrases per frame
package m16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        STOP = 2'd3
    } m16_state_e;

    localparam int PHRASE_WORDS  = 128;
    localparam int FRAME_PHRASES = 32;

endpackage

// File: rtl/m1_word_timer.sv
// Word-slot divider for the M1 frame sequencer.
// Counts 0..WORD_DIV-1. On terminal count it wraps to 0 unless hold is set,
// in which case it parks on the terminal count until hold is released.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   clear - synchronous clear to 0 (sequencer idle)
//   hold  - park on terminal count instead of wrapping
//   tc    - terminal count reached (count == WORD_DIV-1)
module m1_word_timer #(
    parameter int WORD_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tc
);
    import m16_pkg::*;

    localparam logic [15:0] TC_VAL = 16'(WORD_DIV - 1);

    logic [15:0] cnt_r;

    assign tc = (cnt_r == TC_VAL);

    // Slot counter: cleared while idle, wraps at terminal count unless held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= 16'd0;
        end else if (clear) begin
            cnt_r <= 16'd0;
        end else if (tc) begin
            if (hold) begin
                cnt_r <= cnt_r;
            end else begin
                cnt_r <= 16'd0;
            end
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

endmodule

// File: rtl/m1_frame_sequencer.sv
// M1 word filler sequencer for the M16 imitator.
// Issues one-cycle read strobes at a fixed word rate, steps the word pointer
// within a phrase and the group counter across phrases, stalls on serializer
// back-pressure and starts/stops only on phrase boundaries.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   enable       - run request (level)
//   serReady     - serializer can accept the next word
//   bufGetWord   - one-cycle read strobe to the filler
//   bufRdPointer - word index within phrase, stable during the strobe
//   cntGrp       - phrase index within frame
//   wordValid    - bufGetWord delayed by one clock
//   phraseStart  - strobe carries pointer 0
//   frameStart   - strobe carries pointer 0 and group 0
//   busy         - sequencer is not idle
module m1_frame_sequencer
    import m16_pkg::*;
#(
    parameter int WORD_DIV = 16,
    parameter int PTR_W    = $clog2(PHRASE_WORDS),
    parameter int GRP_W    = $clog2(FRAME_PHRASES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             serReady,
    output logic             bufGetWord,
    output logic [PTR_W-1:0] bufRdPointer,
    output logic [GRP_W-1:0] cntGrp,
    output logic             wordValid,
    output logic             phraseStart,
    output logic             frameStart,
    output logic             busy
);

    localparam logic [PTR_W-1:0] PTR_LAST = {PTR_W{1'b1}};

    m16_state_e       state_r, state_nxt_s;
    logic             tc_s, strobe_s, last_word_s;
    logic             buf_get_word_r, word_valid_r, phrase_start_r, frame_start_r, busy_r;
    logic [PTR_W-1:0] ptr_r;
    logic [GRP_W-1:0] grp_r;

    // Divider runs in every state but IDLE; a missing serReady parks it on
    // terminal count, which is what the WAIT state (and a stalled STOP) sits on.
    m1_word_timer #(.WORD_DIV(WORD_DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state_r == IDLE),
        .hold  (!serReady),
        .tc    (tc_s)
    );

    assign last_word_s = (ptr_r == PTR_LAST);

    // Next-state and strobe decode.
    always_comb begin
        state_nxt_s = state_r;
        strobe_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN, WAIT: begin
                strobe_s = tc_s & serReady;
                if (!enable) begin
                    // A deassert landing on the phrase's last strobe ends at once.
                    if (strobe_s && last_word_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = STOP;
                    end
                end else if (tc_s && !serReady) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            STOP: begin
                strobe_s = tc_s & serReady;
                if (enable) begin
                    // Resume without a gap, keeping any pending stall.
                    if (tc_s && !serReady) begin
                        state_nxt_s = WAIT;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else if (strobe_s && last_word_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                strobe_s    = 1'b0;
            end
        endcase
    end

    // State register and registered strobe-related outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            buf_get_word_r <= 1'b0;
            word_valid_r   <= 1'b0;
            phrase_start_r <= 1'b0;
            frame_start_r  <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            buf_get_word_r <= strobe_s;
            word_valid_r   <= buf_get_word_r;
            phrase_start_r <= strobe_s & (ptr_r == '0);
            frame_start_r  <= strobe_s & (ptr_r == '0) & (grp_r == '0);
            busy_r         <= (state_nxt_s != IDLE);
        end
    end

    // Pointer/group advance on the clock after each strobe so the pointer
    // stays stable while the strobe is high; group survives a STOP->IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= '0;
            grp_r <= '0;
        end else if (buf_get_word_r) begin
            ptr_r <= ptr_r + PTR_W'(1);
            if (last_word_s) begin
                grp_r <= grp_r + GRP_W'(1);
            end else begin
                grp_r <= grp_r;
            end
        end else if (state_r == IDLE) begin
            ptr_r <= '0;
            grp_r <= grp_r;
        end else begin
            ptr_r <= ptr_r;
            grp_r <= grp_r;
        end
    end

    assign bufGetWord   = buf_get_word_r;
    assign wordValid    = word_valid_r;
    assign phraseStart  = phrase_start_r;
    assign frameStart   = frame_start_r;
    assign busy         = busy_r;
    assign bufRdPointer = ptr_r;
    assign cntGrp       = grp_r;

endmodule

// File: tb/tb_m1_frame_sequencer.sv
// Directed testbench for m1_frame_sequencer.
// dut16 uses WORD_DIV=16; dut2 uses WORD_DIV=2 for the frame wrap and the
// serReady toggle scenarios.
module tb_m1_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable, serReady;
    logic       bufGetWord, wordValid, phraseStart, frameStart, busy;
    logic [6:0] bufRdPointer;
    logic [4:0] cntGrp;

    logic       enable2, serReady2;
    logic       bgw2, wv2, ps2, fs2, busy2;
    logic [6:0] ptr2;
    logic [4:0] grp2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m1_frame_sequencer #(.WORD_DIV(16)) dut16 (
        .clk(clk), .reset(reset), .enable(enable), .serReady(serReady),
        .bufGetWord(bufGetWord), .bufRdPointer(bufRdPointer), .cntGrp(cntGrp),
        .wordValid(wordValid), .phraseStart(phraseStart), .frameStart(frameStart),
        .busy(busy)
    );

    m1_frame_sequencer #(.WORD_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable2), .serReady(serReady2),
        .bufGetWord(bgw2), .bufRdPointer(ptr2), .cntGrp(grp2),
        .wordValid(wv2), .phraseStart(ps2), .frameStart(fs2),
        .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks at least once, until dut16 strobes or max edges elapse.
    task automatic count_to_strobe(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bufGetWord && n < max);
    endtask

    task automatic count_to_strobe2(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bgw2 && n < max);
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; serReady = 1'b0; enable2 = 1'b0; serReady2 = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({bufGetWord, wordValid, phraseStart, frameStart, busy, bufRdPointer, cntGrp} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {bufGetWord, wordValid, phraseStart, frameStart, busy, bufRdPointer, cntGrp});
        end
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || bufGetWord !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b strobe=%b required 0 0", busy, bufGetWord);
        end
    endtask

    task automatic test_first_strobe();
        int n;
        serReady = 1'b1;
        enable   = 1'b1;
        // Edge 1 samples enable; strobe 16 edges after that.
        count_to_strobe(40, n);
        checks++;
        if (n !== 17) begin errors++; $display("FAIL first_strobe_latency: got %0d required 17", n); end
        checks++;
        if (bufRdPointer !== 7'd0 || phraseStart !== 1'b1 || frameStart !== 1'b1 || cntGrp !== 5'd0) begin
            errors++;
            $display("FAIL first_strobe_fields: ptr=%0d ps=%b fs=%b grp=%0d required 0 1 1 0", bufRdPointer, phraseStart, frameStart, cntGrp);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_run: got %b required 1", busy); end
        tick();
        checks++;
        if (wordValid !== 1'b1 || bufGetWord !== 1'b0 || bufRdPointer !== 7'd1) begin
            errors++;
            $display("FAIL word_valid_delay: wv=%b strobe=%b ptr=%0d required 1 0 1", wordValid, bufGetWord, bufRdPointer);
        end
        count_to_strobe(40, n);
        checks++;
        if (n !== 15 || bufRdPointer !== 7'd1 || phraseStart !== 1'b0) begin
            errors++;
            $display("FAIL second_strobe: n=%0d ptr=%0d ps=%b required 15 1 0", n, bufRdPointer, phraseStart);
        end
    endtask

    task automatic test_phrase_wrap();
        int n;
        for (int k = 2; k <= 128; k++) begin
            count_to_strobe(40, n);
            checks++;
            if (n !== 16 || bufRdPointer !== 7'(k)) begin
                errors++;
                $display("FAIL phrase_step: strobe %0d n=%0d ptr=%0d required 16 %0d", k + 1, n, bufRdPointer, k % 128);
            end
        end
        checks++;
        if (cntGrp !== 5'd1 || phraseStart !== 1'b1 || frameStart !== 1'b0) begin
            errors++;
            $display("FAIL phrase_wrap: grp=%0d ps=%b fs=%b required 1 1 0", cntGrp, phraseStart, frameStart);
        end
    endtask

    task automatic test_ready_hold();
        int n;
        int seen;
        seen = 0;
        serReady = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bufGetWord) seen++;
        end
        checks++;
        if (seen !== 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_no_strobe: strobes=%0d busy=%b required 0 1", seen, busy);
        end
        serReady = 1'b1;
        tick();
        checks++;
        if (bufGetWord !== 1'b1 || bufRdPointer !== 7'd1 || cntGrp !== 5'd1) begin
            errors++;
            $display("FAIL hold_release: strobe=%b ptr=%0d grp=%0d required 1 1 1", bufGetWord, bufRdPointer, cntGrp);
        end
        count_to_strobe(40, n);
        checks++;
        if (n !== 16 || bufRdPointer !== 7'd2) begin
            errors++;
            $display("FAIL hold_next: n=%0d ptr=%0d required 16 2", n, bufRdPointer);
        end
    endtask

    task automatic test_stop_restart();
        int n;
        int seen;
        for (int k = 3; k <= 10; k++) count_to_strobe(40, n);
        checks++;
        if (bufRdPointer !== 7'd10) begin errors++; $display("FAIL stop_setup: ptr=%0d required 10", bufRdPointer); end
        enable = 1'b0;
        for (int k = 11; k <= 127; k++) begin
            count_to_strobe(40, n);
            checks++;
            if (n !== 16 || bufRdPointer !== 7'(k)) begin
                errors++;
                $display("FAIL stop_drain: n=%0d ptr=%0d required 16 %0d", n, bufRdPointer, k);
            end
            if (k == 126) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL stop_busy: got %b required 1", busy); end
            end
        end
        checks++;
        if (busy !== 1'b0 || bufGetWord !== 1'b1) begin
            errors++;
            $display("FAIL stop_last: busy=%b strobe=%b required 0 1", busy, bufGetWord);
        end
        tick();
        checks++;
        if (wordValid !== 1'b1 || bufRdPointer !== 7'd0 || cntGrp !== 5'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: wv=%b ptr=%0d grp=%0d busy=%b required 1 0 2 0", wordValid, bufRdPointer, cntGrp, busy);
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bufGetWord || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL idle_quiet: active=%0d required 0", seen); end
        enable = 1'b1;
        count_to_strobe(40, n);
        checks++;
        if (n !== 17 || bufRdPointer !== 7'd0 || cntGrp !== 5'd2 || phraseStart !== 1'b1 || frameStart !== 1'b0) begin
            errors++;
            $display("FAIL restart: n=%0d ptr=%0d grp=%0d ps=%b fs=%b required 17 0 2 1 0", n, bufRdPointer, cntGrp, phraseStart, frameStart);
        end
    endtask

    task automatic test_reset_mid_word();
        int n;
        int seen;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({bufGetWord, wordValid, phraseStart, frameStart, busy, bufRdPointer, cntGrp} !== 17'd0) begin
            errors++;
            $display("FAIL async_reset: got %b required 0", {bufGetWord, wordValid, phraseStart, frameStart, busy, bufRdPointer, cntGrp});
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bufGetWord) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_no_strobe: strobes=%0d required 0", seen); end
        reset = 1'b1;
        count_to_strobe(40, n);
        checks++;
        if (n !== 17 || bufRdPointer !== 7'd0 || cntGrp !== 5'd0 || frameStart !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart: n=%0d ptr=%0d grp=%0d fs=%b required 17 0 0 1", n, bufRdPointer, cntGrp, frameStart);
        end
    endtask

    task automatic test_frame_wrap();
        int n;
        serReady2 = 1'b1;
        enable2   = 1'b1;
        for (int s = 0; s <= 4096; s++) begin
            count_to_strobe2(10, n);
            checks++;
            if (n !== ((s == 0) ? 3 : 2) || ptr2 !== 7'(s % 128) || grp2 !== 5'((s / 128) % 32)) begin
                errors++;
                $display("FAIL frame_step: strobe %0d n=%0d ptr=%0d grp=%0d required ptr %0d grp %0d", s, n, ptr2, grp2, s % 128, (s / 128) % 32);
            end
            if (s == 128) begin
                checks++;
                if (ps2 !== 1'b1 || fs2 !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_phrase1: ps=%b fs=%b required 1 0", ps2, fs2);
                end
            end
        end
        checks++;
        if (grp2 !== 5'd0 || fs2 !== 1'b1 || ps2 !== 1'b1) begin
            errors++;
            $display("FAIL frame_wrap: grp=%0d fs=%b ps=%b required 0 1 1", grp2, fs2, ps2);
        end
    endtask

    task automatic test_ready_toggle();
        logic [6:0] last_ptr;
        logic       prev_strobe;
        int         strobes;
        last_ptr    = 7'd0;
        prev_strobe = 1'b1;
        strobes     = 0;
        for (int i = 0; i < 200; i++) begin
            serReady2 = ~serReady2;
            tick();
            if (bgw2) begin
                strobes++;
                checks++;
                if (prev_strobe !== 1'b0 || ptr2 !== last_ptr + 7'd1) begin
                    errors++;
                    $display("FAIL toggle_strobe: adjacent=%b ptr=%0d required 0 %0d", prev_strobe, ptr2, last_ptr + 7'd1);
                end
                last_ptr = ptr2;
            end
            prev_strobe = bgw2;
        end
        checks++;
        if (strobes < 40) begin errors++; $display("FAIL toggle_rate: strobes=%0d required >=40", strobes); end
    endtask

    initial begin
        test_reset();
        test_first_strobe();
        test_phrase_wrap();
        test_ready_hold();
        test_stop_restart();
        test_reset_mid_word();
        test_frame_wrap();
        test_ready_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
